// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared memory port arbiter between fetch (I) and memory-access (D) stages
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_DBURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ireq_valid,
  input  logic [AW-1:0]   ireq_addr,
  output logic            ireq_done,
  output logic [DW-1:0]   ireq_data,
  input  logic            dreq_valid,
  input  logic            dreq_write,
  input  logic [AW-1:0]   dreq_addr,
  input  logic [DW-1:0]   dreq_wdata,
  input  logic [DW/8-1:0] dreq_strobe,
  output logic            dreq_done,
  output logic [DW-1:0]   dreq_data,
  output logic            mem_valid,
  output logic            mem_write,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_strobe,
  input  logic            mem_ready,
  input  logic [DW-1:0]   mem_rdata,
  output logic            stall_if,
  output logic            stall_mem
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  localparam logic [3:0] MAXC = 4'(MAX_DBURST);

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            grant_d, grant_i, complete;
  logic            write_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] strobe_q;

  // Grant decision, completion and burst-counter update
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (dreq_valid && !(ireq_valid && cnt == MAXC)) begin
          grant_d   = 1'b1;
          state_nxt = DBUSY;
          if (ireq_valid)
            cnt_nxt = (cnt == MAXC) ? cnt : cnt + 4'd1;
          else
            cnt_nxt = 4'd0;
        end else if (ireq_valid) begin
          grant_i   = 1'b1;
          state_nxt = IBUSY;
          cnt_nxt   = 4'd0;
        end
      end
      IBUSY, DBUSY: begin
        if (mem_ready) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and burst counter registers; reset abandons any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture the granted request so the memory sees stable fields until ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strobe_q <= '0;
    end else if (grant_d) begin
      write_q  <= dreq_write;
      addr_q   <= dreq_addr;
      wdata_q  <= dreq_wdata;
      strobe_q <= dreq_strobe;
    end else if (grant_i) begin
      write_q  <= 1'b0;
      addr_q   <= ireq_addr;
      wdata_q  <= '0;
      strobe_q <= '0;
    end else if (complete) begin
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strobe_q <= '0;
    end
  end

  // Memory request is purely registered; valid follows the busy states
  always_comb begin
    mem_valid  = (state != IDLE);
    mem_write  = write_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    mem_strobe = strobe_q;
  end

  // Completion steering and stall generation
  always_comb begin
    ireq_done = (state == IBUSY) && mem_ready;
    dreq_done = (state == DBUSY) && mem_ready;
    ireq_data = mem_rdata;
    dreq_data = mem_rdata;
    stall_if  = ireq_valid && !ireq_done;
    stall_mem = dreq_valid && !dreq_done;
  end

endmodule
